vga_pattern_sched: RTL
======================

# vga_pattern_sched

Frame-synchronous pattern scheduler for the VGA picture path. It selects which of NUM_PAT picture generators drives the pixel bus. Examples of generators are the colour-bar generator and later test patterns. Each generator is clocked by vga_clk and driven from the same pic_x/pic_y coordinates. Pattern changes come from an auto-advance timer or from a debounced push-button, and are committed only at the end of a frame, so the image never tears. The block sits between the generator bank and the VGA timing/output stage.

## Interface
- NUM_PAT, 4: number of pattern sources, 2..8.
- H_VALID, 10'd640: active pixels per line.
- V_VALID, 10'd480: active lines per frame.
- FRAMES_PER_PAT, 60: frames shown per pattern in auto mode, 1..255.
- DEB_CYCLES, 250000: stable cycles needed to accept a button level, which is 10 ms at 25 MHz.

Ports:
- vga_clk  in  1: pixel clock, the only clock.
- rst_n  in  1: reset, asynchronous, active-low.
- pic_x  in  10: current pixel column.
- pic_y  in  10: current pixel row.
- src_data  in  16*NUM_PAT: RGB565 outputs of the generators. Source k occupies bits [16k+15:16k].
- btn_next  in  1: raw push-button, active-high, asynchronous, bouncy.
- auto_en  in  1: 1 selects auto-advance mode; 0 selects manual mode.
- pat_sel  out  3: index of the pattern currently displayed.
- pic_data  out  16: selected RGB565 pixel, registered.
- frame_end  out  1: one-cycle pulse after the last active pixel of each frame.
- pat_switch  out  1: one-cycle pulse, coincident with frame_end, when pat_sel changed.

## Operation
- **Frame detect:**
  - last_px is true when pic_x == H_VALID-1 and pic_y == V_VALID-1.
  - frame_end is registered from last_px.
- **Button path:**
  - A 2-flop synchroniser feeds a debounce counter.
  - When the synchronised level differs from the accepted level, the counter increments.
  - The counter resets whenever the two levels are equal again.
  - When the count reaches DEB_CYCLES-1, the accepted level takes the synchronised value.
  - A 0->1 transition of the accepted level sets a sticky press_pend flag.
  - press_pend clears only at a frame commit, or on reset.
  - Multiple presses within one frame collapse to a single advance.
- **Modes and state machine:**
  - MANUAL (auto_en=0):
    - On last_px, if press_pend, advance.
    - frame_cnt is held at 0.
  - AUTO (auto_en=1):
    - On last_px, frame_cnt increments.
    - If frame_cnt == FRAMES_PER_PAT-1 or press_pend, then advance and set frame_cnt to 0.
  - Transition MANUAL->AUTO or AUTO->MANUAL follows auto_en, sampled every cycle.
  - Any mode change clears frame_cnt to 0, so the auto period restarts.
- **Advance:**
  - pat_sel becomes pat_sel+1.
  - It wraps from NUM_PAT-1 to 0.
  - pat_switch is asserted.
- **Simultaneous events:**
  - Auto expiry and press_pend in the same frame give exactly one advance (+1), never +2.
  - A button press accepted on the same cycle as last_px is counted for this frame.
- **Mux:**
  - pic_data <= src_data[16*pat_sel +: 16] every cycle.
  - The mux uses the registered pat_sel.
- **Out-of-range coordinates:** pic_x/pic_y outside the active area never produce last_px.

## Timing
- **Reset values:** all outputs and internal state are 0 while rst_n=0. This covers pat_sel, pic_data, frame_end, pat_switch, frame_cnt, press_pend, the accepted button level and the debounce counter.
- **Frame commit:** with last_px true at edge T, at T+1 frame_end=1, the new pat_sel is visible, and pat_switch=1 if an advance occurred.
- **Mux latency:** pic_data has 1 cycle latency from src_data. The last active pixel uses the old pattern; the first pixel of the next frame uses the new one.
- **Button latency:** a clean button press becomes press_pend 2 + DEB_CYCLES cycles after btn_next rises, ±1 cycle.
- **Bounce rejection:** a glitch shorter than DEB_CYCLES cycles is ignored.
- **Reset mid-frame:** an asynchronous rst_n assertion returns everything to reset values immediately. After release, operation resumes at the next last_px with pat_sel=0.

## Test plan
Use H_VALID=16, V_VALID=8, FRAMES_PER_PAT=3, DEB_CYCLES=8 and NUM_PAT=4. Drive pic_x/pic_y from a simple raster counter, and give source k a constant value of 16'h1111*(k+1).

- **Reset:** assert rst_n=0 mid-frame -> all outputs 0 at once. After release, pic_data reads 16'h1111 one cycle later.
- **Auto advance:** auto_en=1, no button -> pat_switch at frame ends 3, 6, 9 and 12. pat_sel goes 1, 2, 3, 0 (wrap). pic_data follows 16'h2222, 3333, 4444, 1111.
- **Manual press:** auto_en=0, btn_next held high for 20 cycles mid-frame -> pat_sel does not change until that frame's frame_end, then 0->1. Three separate presses in one frame still give +1 only.
- **Bounce rejection:** btn_next pulses of 5 cycles high and 3 low, repeated -> no press_pend and no pat_sel change.
- **Simultaneous events:** press accepted during the 3rd auto frame -> a single advance (+1) at that frame end, and frame_cnt restarts at 0.
- **Mode switch:** toggle auto_en 1->0->1 after 2 frames -> the auto period restarts, and the next advance comes 3 frames after re-entry.

Source files
------------

// File: rtl/vga_pattern_sched_if.sv
// Pixel-path bundle between the generator bank / timing stage and the pattern
// scheduler.
//   pic_x, pic_y  : raster coordinates of the current pixel
//   src_data      : RGB565 outputs of all generators, source k at [16k+15:16k]
//   btn_next      : raw, bouncy, asynchronous push-button (active-high)
//   auto_en       : 1 = auto-advance mode, 0 = manual mode
//   pat_sel       : index of the pattern being displayed
//   pic_data      : selected RGB565 pixel (registered)
//   frame_end     : one-cycle pulse after the last active pixel of a frame
//   pat_switch    : one-cycle pulse with frame_end when pat_sel changed
// The master drives coordinates, sources and controls; the slave (scheduler)
// returns the selected pixel and status.
interface vga_pattern_sched_if #(
  parameter int NUM_PAT = 4
);
  logic [9:0]             pic_x;
  logic [9:0]             pic_y;
  logic [16*NUM_PAT-1:0]  src_data;
  logic                   btn_next;
  logic                   auto_en;
  logic [2:0]             pat_sel;
  logic [15:0]            pic_data;
  logic                   frame_end;
  logic                   pat_switch;

  modport master (
    output pic_x, pic_y, src_data, btn_next, auto_en,
    input  pat_sel, pic_data, frame_end, pat_switch
  );

  modport slave (
    input  pic_x, pic_y, src_data, btn_next, auto_en,
    output pat_sel, pic_data, frame_end, pat_switch
  );
endinterface

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous pattern scheduler for the VGA picture path.
// Selects one of NUM_PAT generator outputs onto the pixel bus. Pattern changes
// come from an auto-advance frame timer or a debounced push-button and are
// committed only on the last active pixel of a frame, so the picture never
// tears.
// Ports:
//   vga_clk : pixel clock (only clock)
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of vga_pattern_sched_if (coordinates, sources,
//             button, mode in; pat_sel, pic_data, frame_end, pat_switch out)
module vga_pattern_sched #(
  parameter int         NUM_PAT        = 4,
  parameter logic [9:0] H_VALID        = 10'd640,
  parameter logic [9:0] V_VALID        = 10'd480,
  parameter int         FRAMES_PER_PAT = 60,
  parameter int         DEB_CYCLES     = 250000
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  vga_pattern_sched_if.slave bus
);

  localparam int            DW         = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAMES_PER_PAT - 1);
  localparam logic [2:0]    PAT_LAST   = 3'(NUM_PAT - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  mode_t          state, state_nxt;

  logic           btn_s1, btn_s2, btn_lvl;
  logic [DW-1:0]  deb_cnt;
  logic           press_pend;
  logic [7:0]     frame_cnt, frame_cnt_nxt;
  logic [2:0]     pat_sel_q, pat_sel_nxt;
  logic [15:0]    pic_data_q;
  logic           frame_end_q, pat_switch_q;

  logic           last_px, deb_hit, press_rise, press_now, expire, advance;

  // Sources padded to 8 entries so the 3-bit pat_sel indexes them exactly.
  logic [15:0]    src_arr [8];

  for (genvar k = 0; k < 8; k++) begin : g_src
    if (k < NUM_PAT) begin : g_on
      assign src_arr[k] = bus.src_data[16*k +: 16];
    end else begin : g_off
      assign src_arr[k] = '0;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = bus.auto_en ? AUTO : MANUAL;

    last_px = (bus.pic_x == H_VALID - 10'd1) && (bus.pic_y == V_VALID - 10'd1);

    deb_hit    = (btn_s2 != btn_lvl) && (deb_cnt == DEB_LAST);
    press_rise = deb_hit && btn_s2;
    // A press accepted on the commit cycle itself still counts for this frame.
    press_now  = press_pend || press_rise;

    expire  = (state == AUTO) && (frame_cnt == FRAME_LAST);
    // Expiry and a pending press share one advance, never two.
    advance = last_px && (press_now || expire);

    pat_sel_nxt = pat_sel_q;
    if (advance) begin
      pat_sel_nxt = (pat_sel_q == PAT_LAST) ? '0 : pat_sel_q + 3'd1;
    end

    frame_cnt_nxt = frame_cnt;
    if ((state_nxt != state) || (state == MANUAL)) begin
      frame_cnt_nxt = '0;
    end else if (last_px) begin
      frame_cnt_nxt = advance ? '0 : frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_lvl      <= 1'b0;
      deb_cnt      <= '0;
      press_pend   <= 1'b0;
      frame_cnt    <= '0;
      pat_sel_q    <= '0;
      pic_data_q   <= '0;
      frame_end_q  <= 1'b0;
      pat_switch_q <= 1'b0;
    end else begin
      btn_s1 <= bus.btn_next;
      btn_s2 <= btn_s1;

      if (btn_s2 == btn_lvl) begin
        deb_cnt <= '0;
      end else if (deb_hit) begin
        btn_lvl <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      // Every commit consumes the pending press, whichever mode is active.
      press_pend   <= last_px ? 1'b0 : press_now;
      frame_cnt    <= frame_cnt_nxt;
      pat_sel_q    <= pat_sel_nxt;
      pic_data_q   <= src_arr[pat_sel_q];
      frame_end_q  <= last_px;
      pat_switch_q <= advance;
    end
  end

  assign bus.pat_sel    = pat_sel_q;
  assign bus.pic_data   = pic_data_q;
  assign bus.frame_end  = frame_end_q;
  assign bus.pat_switch = pat_switch_q;

endmodule
